// File: rtl/ascii_inst_pkg.sv
// ASCII byte constants for the JSON command framing, plus a digit classifier.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package ascii_inst_pkg;

    localparam logic [7:0] ASCII_LBRACE    = 8'h7B;
    localparam logic [7:0] ASCII_RBRACE    = 8'h7D;
    localparam logic [7:0] ASCII_QUOTE     = 8'h22;
    localparam logic [7:0] ASCII_COLON     = 8'h3A;
    localparam logic [7:0] ASCII_COMMA     = 8'h2C;
    localparam logic [7:0] ASCII_DOT       = 8'h2E;
    localparam logic [7:0] ASCII_MINUS     = 8'h2D;
    localparam logic [7:0] ASCII_LINE_FEED = 8'h0A;
    localparam logic [7:0] ASCII_T         = 8'h54;
    localparam logic [7:0] ASCII_L         = 8'h4C;
    localparam logic [7:0] ASCII_R         = 8'h52;
    localparam logic [7:0] ASCII_0         = 8'h30;
    localparam logic [7:0] ASCII_1         = 8'h31;
    localparam logic [7:0] ASCII_2         = 8'h32;
    localparam logic [7:0] ASCII_3         = 8'h33;
    localparam logic [7:0] ASCII_4         = 8'h34;
    localparam logic [7:0] ASCII_5         = 8'h35;
    localparam logic [7:0] ASCII_6         = 8'h36;
    localparam logic [7:0] ASCII_7         = 8'h37;
    localparam logic [7:0] ASCII_8         = 8'h38;
    localparam logic [7:0] ASCII_9         = 8'h39;

    // True for the ten decimal digit characters; the low nibble is then the digit value.
    function automatic logic is_digit(input logic [7:0] b);
        return b inside {ASCII_0, ASCII_1, ASCII_2, ASCII_3, ASCII_4,
                         ASCII_5, ASCII_6, ASCII_7, ASCII_8, ASCII_9};
    endfunction

endpackage

// File: rtl/motor_cmd_pkg.sv
// Shared motor command encoding used by both the JSON sender and the JSON parser.
// Latency: n/a (types only).
// Backpressure: n/a.
package motor_cmd_pkg;

    typedef enum logic [4:0] {
        MC_STOP    = 5'b00001,
        MC_FORWARD = 5'b00010,
        MC_RIGHT   = 5'b00100,
        MC_LEFT    = 5'b01000,
        MC_SPIN    = 5'b10000
    } motor_cmd_e;

endpackage

// File: rtl/json_num_accum.sv
// Decimal accumulator: builds a signed milli-unit value from sign, one integer digit and up to 3 fraction digits.
// Latency: value reflects a digit strobe on the cycle after the strobe.
// Backpressure: none; the caller strobes at most one digit per cycle.
module json_num_accum #(
    parameter int VAL_W = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clr_i,
    input  logic                    neg_i,
    input  logic                    dig_vld_i,
    input  logic [1:0]              dig_pos_i,
    input  logic [3:0]              dig_i,
    output logic signed [VAL_W-1:0] val_o
);

    // Magnitude never exceeds 9999, so 14 bits hold it exactly.
    logic [13:0] mag_q;
    logic        neg_q;
    logic [13:0] wt_d;
    logic [13:0] add_d;
    logic signed [VAL_W-1:0] mag_s;

    // Positional weight: integer digit x1000, then fraction digits x100, x10, x1.
    always_comb begin
        wt_d = 14'd1;
        case (dig_pos_i)
            2'd0:    wt_d = 14'd1000;
            2'd1:    wt_d = 14'd100;
            2'd2:    wt_d = 14'd10;
            default: wt_d = 14'd1;
        endcase
        add_d = wt_d * {10'd0, dig_i};
    end

    // Clear wins over any strobe so a new field always starts from zero.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            mag_q <= '0;
            neg_q <= 1'b0;
        end else begin
            if (dig_vld_i) mag_q <= mag_q + add_d;
            if (neg_i)     neg_q <= 1'b1;
        end
    end

    assign mag_s = {{(VAL_W-14){1'b0}}, mag_q};
    assign val_o = neg_q ? -mag_s : mag_s;

endmodule

// File: rtl/json_uart_parser.sv
// Parses {"T":d,"L":n,"R":n}+LF frames from a UART byte stream into signed milli speeds and a one-hot motor command.
// Latency: outputs and cmd_valid appear 2 cycles after the LF handshake; parse_error 1 cycle after the bad byte.
// Backpressure: uart_ready is low only during the single EMIT cycle; one byte per cycle otherwise.
module json_uart_parser #(
    parameter int VAL_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              uart_data,
    input  logic                    uart_valid,
    output logic                    uart_ready,
    output logic signed [VAL_W-1:0] left_speed,
    output logic signed [VAL_W-1:0] right_speed,
    output logic [3:0]              type_id,
    output logic [4:0]              motor_cmd,
    output logic                    cmd_valid,
    output logic                    parse_error
);

    import motor_cmd_pkg::*;
    import ascii_inst_pkg::*;

    typedef enum logic [3:0] {
        ST_IDLE, ST_KEY_OQ, ST_KEY, ST_KEY_CQ, ST_COLON, ST_T_DIG, ST_SIGN_INT,
        ST_DOT, ST_FRAC, ST_AFTER_FRAC, ST_SEP, ST_EOL, ST_EMIT
    } state_e;

    typedef enum logic [1:0] {KEY_T, KEY_L, KEY_R} key_e;

    localparam logic signed [VAL_W-1:0] ZERO = '0;

    state_e                  state_q;
    key_e                    key_q;
    logic                    minus_q;
    logic [1:0]              fcnt_q;
    logic [3:0]              t_stg_q;
    logic signed [VAL_W-1:0] l_stg_q;
    logic signed [VAL_W-1:0] r_stg_q;
    logic                    ready_q;
    logic signed [VAL_W-1:0] left_q;
    logic signed [VAL_W-1:0] right_q;
    logic [3:0]              type_q;
    motor_cmd_e              cmd_q;
    logic                    cmd_valid_q;
    logic                    err_q;

    logic                    hs;
    logic                    dig;
    logic                    byte_ok_d;
    logic [7:0]              key_char_d;
    logic [7:0]              sep_char_d;
    motor_cmd_e              cls_d;
    logic                    acc_clr;
    logic                    acc_neg;
    logic                    acc_dig_vld;
    logic [1:0]              acc_pos;
    logic signed [VAL_W-1:0] acc_val;

    assign hs  = uart_valid && ready_q;
    assign dig = is_digit(uart_data);

    // Key character and closing separator both follow the expected-key register.
    always_comb begin
        key_char_d = ASCII_T;
        sep_char_d = ASCII_COMMA;
        case (key_q)
            KEY_L:   key_char_d = ASCII_L;
            KEY_R:   begin key_char_d = ASCII_R; sep_char_d = ASCII_RBRACE; end
            default: key_char_d = ASCII_T;
        endcase
    end

    // Legality of the current byte in the current state; IDLE accepts anything silently.
    always_comb begin
        byte_ok_d = 1'b0;
        case (state_q)
            ST_IDLE:       byte_ok_d = 1'b1;
            ST_KEY_OQ,
            ST_KEY_CQ:     byte_ok_d = (uart_data == ASCII_QUOTE);
            ST_KEY:        byte_ok_d = (uart_data == key_char_d);
            ST_COLON:      byte_ok_d = (uart_data == ASCII_COLON);
            ST_T_DIG:      byte_ok_d = dig;
            ST_SIGN_INT:   byte_ok_d = dig || (uart_data == ASCII_MINUS && !minus_q);
            ST_DOT:        byte_ok_d = (uart_data == ASCII_DOT);
            ST_FRAC:       byte_ok_d = dig;
            ST_AFTER_FRAC: byte_ok_d = (dig && fcnt_q != 2'd3) || (uart_data == sep_char_d);
            ST_SEP:        byte_ok_d = (uart_data == ASCII_COMMA);
            ST_EOL:        byte_ok_d = (uart_data == ASCII_LINE_FEED);
            default:       byte_ok_d = 1'b0;
        endcase
    end

    assign acc_clr     = hs && state_q == ST_COLON && byte_ok_d;
    assign acc_neg     = hs && state_q == ST_SIGN_INT && uart_data == ASCII_MINUS && !minus_q;
    assign acc_dig_vld = hs && dig && (state_q == ST_SIGN_INT || state_q == ST_FRAC ||
                                       (state_q == ST_AFTER_FRAC && fcnt_q != 2'd3));
    assign acc_pos     = (state_q == ST_SIGN_INT) ? 2'd0 : 2'(fcnt_q + 2'd1);

    json_num_accum #(.VAL_W(VAL_W)) u_num_accum (
        .clk_i     (clk),
        .rst_i     (rst),
        .clr_i     (acc_clr),
        .neg_i     (acc_neg),
        .dig_vld_i (acc_dig_vld),
        .dig_pos_i (acc_pos),
        .dig_i     (uart_data[3:0]),
        .val_o     (acc_val)
    );

    // Classify staged L/R into the motor command; first matching rule wins.
    always_comb begin
        cls_d = MC_STOP;
        if (l_stg_q == ZERO && r_stg_q == ZERO)                      cls_d = MC_STOP;
        else if (l_stg_q == r_stg_q && l_stg_q > ZERO)               cls_d = MC_FORWARD;
        else if (l_stg_q > ZERO && r_stg_q < ZERO && l_stg_q == -r_stg_q) cls_d = MC_SPIN;
        else if (l_stg_q > r_stg_q)                                  cls_d = MC_RIGHT;
        else if (l_stg_q < r_stg_q)                                  cls_d = MC_LEFT;
        else                                                         cls_d = MC_STOP;
    end

    // Frame FSM with staging and registered outputs; a bad '{' restarts a frame rather than idling.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            key_q       <= KEY_T;
            minus_q     <= 1'b0;
            fcnt_q      <= 2'd0;
            t_stg_q     <= '0;
            l_stg_q     <= '0;
            r_stg_q     <= '0;
            ready_q     <= 1'b0;
            left_q      <= '0;
            right_q     <= '0;
            type_q      <= '0;
            cmd_q       <= MC_STOP;
            cmd_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            cmd_valid_q <= 1'b0;
            err_q       <= 1'b0;
            ready_q     <= 1'b1;
            if (state_q == ST_EMIT) begin
                left_q      <= l_stg_q;
                right_q     <= r_stg_q;
                type_q      <= t_stg_q;
                cmd_q       <= cls_d;
                cmd_valid_q <= 1'b1;
                state_q     <= ST_IDLE;
            end else if (hs) begin
                if (!byte_ok_d) begin
                    err_q   <= 1'b1;
                    key_q   <= KEY_T;
                    state_q <= (uart_data == ASCII_LBRACE) ? ST_KEY_OQ : ST_IDLE;
                end else begin
                    case (state_q)
                        ST_IDLE: if (uart_data == ASCII_LBRACE) begin
                            key_q   <= KEY_T;
                            state_q <= ST_KEY_OQ;
                        end
                        ST_KEY_OQ: state_q <= ST_KEY;
                        ST_KEY:    state_q <= ST_KEY_CQ;
                        ST_KEY_CQ: state_q <= ST_COLON;
                        ST_COLON: begin
                            minus_q <= 1'b0;
                            fcnt_q  <= 2'd0;
                            state_q <= (key_q == KEY_T) ? ST_T_DIG : ST_SIGN_INT;
                        end
                        ST_T_DIG: begin
                            t_stg_q <= uart_data[3:0];
                            state_q <= ST_SEP;
                        end
                        ST_SIGN_INT: begin
                            if (uart_data == ASCII_MINUS) minus_q <= 1'b1;
                            else                          state_q <= ST_DOT;
                        end
                        ST_DOT: state_q <= ST_FRAC;
                        ST_FRAC: begin
                            fcnt_q  <= 2'd1;
                            state_q <= ST_AFTER_FRAC;
                        end
                        ST_AFTER_FRAC: begin
                            if (dig) begin
                                fcnt_q <= fcnt_q + 2'd1;
                            end else if (key_q == KEY_L) begin
                                l_stg_q <= acc_val;
                                key_q   <= KEY_R;
                                state_q <= ST_KEY_OQ;
                            end else begin
                                r_stg_q <= acc_val;
                                state_q <= ST_EOL;
                            end
                        end
                        ST_SEP: begin
                            key_q   <= KEY_L;
                            state_q <= ST_KEY_OQ;
                        end
                        ST_EOL: begin
                            ready_q <= 1'b0;
                            state_q <= ST_EMIT;
                        end
                        default: state_q <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    assign uart_ready  = ready_q;
    assign left_speed  = left_q;
    assign right_speed = right_q;
    assign type_id     = type_q;
    assign motor_cmd   = cmd_q;
    assign cmd_valid   = cmd_valid_q;
    assign parse_error = err_q;

endmodule

// File: tb/tb_json_uart_parser.sv
// Self-checking bench: byte-stream driver, scoreboard of expected commands, parse_error counting.
// Latency: checks cmd_valid two cycles after the LF handshake on the first frame.
// Backpressure: driver holds each byte until uart_ready is seen high.
module tb_json_uart_parser;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [7:0]         uart_data = 8'h00;
    logic               uart_valid = 1'b0;
    logic               uart_ready;
    logic signed [15:0] left_speed;
    logic signed [15:0] right_speed;
    logic [3:0]         type_id;
    logic [4:0]         motor_cmd;
    logic               cmd_valid;
    logic               parse_error;

    typedef struct {
        int l;
        int r;
        int t;
        int cmd;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   err_seen  = 0;
    int   err_exp   = 0;
    int   cmd_seen  = 0;
    int   cmd_exp   = 0;
    int   last_l    = 0;
    int   last_r    = 0;
    int   last_t    = 0;
    int   last_cmd  = 1;

    json_uart_parser #(.VAL_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .uart_data   (uart_data),
        .uart_valid  (uart_valid),
        .uart_ready  (uart_ready),
        .left_speed  (left_speed),
        .right_speed (right_speed),
        .type_id     (type_id),
        .motor_cmd   (motor_cmd),
        .cmd_valid   (cmd_valid),
        .parse_error (parse_error)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // Scoreboard side: every cmd_valid pulse pops one expected command.
    always @(negedge clk) begin
        if (parse_error) err_seen++;
        if (cmd_valid) begin
            cmd_seen++;
            check_eq("sb_nonempty", int'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check_eq("left_speed",  int'(left_speed),  e.l);
                check_eq("right_speed", int'(right_speed), e.r);
                check_eq("type_id",     int'(type_id),     e.t);
                check_eq("motor_cmd",   int'(motor_cmd),   e.cmd);
                last_l = e.l; last_r = e.r; last_t = e.t; last_cmd = e.cmd;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int guard;
        uart_data  = b;
        uart_valid = 1'b1;
        guard      = 0;
        while (!uart_ready && guard < 16) begin
            @(negedge clk);
            guard++;
        end
        if (!uart_ready) check_eq("ready_timeout", int'(uart_ready), 1);
        @(negedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic push_exp(input int l, input int r, input int t, input int cmd);
        exp_t e;
        e.l = l; e.r = r; e.t = t; e.cmd = cmd;
        sb_q.push_back(e);
        cmd_exp++;
    endtask

    task automatic send_frame(input string s, input int l, input int r, input int t, input int cmd);
        push_exp(l, r, t, cmd);
        send_str(s);
        send_byte(8'h0A);
    endtask

    task automatic idle(input int n);
        uart_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_held(input string tag);
        check_eq({tag, "_left"},  int'(left_speed),  last_l);
        check_eq({tag, "_right"}, int'(right_speed), last_r);
        check_eq({tag, "_type"},  int'(type_id),     last_t);
        check_eq({tag, "_cmd"},   int'(motor_cmd),   last_cmd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check_eq("rst_ready",       int'(uart_ready),  0);
        check_eq("rst_cmd_valid",   int'(cmd_valid),   0);
        check_eq("rst_parse_error", int'(parse_error), 0);
        check_held("rst");
        rst = 1'b0;
        @(negedge clk);
        check_eq("ready_after_rst", int'(uart_ready), 1);

        // FORWARD with exact completion timing
        push_exp(150, 150, 1, 5'b00010);
        send_str("{\"T\":1,\"L\":0.150,\"R\":0.150}");
        send_byte(8'h0A);
        check_eq("emit_ready_low",   int'(uart_ready), 0);
        check_eq("emit_no_cmd_yet",  int'(cmd_valid),  0);
        uart_valid = 1'b0;
        @(negedge clk);
        check_eq("n2_ready_high",    int'(uart_ready), 1);
        check_eq("n2_cmd_valid",     int'(cmd_valid),  1);
        @(negedge clk);
        check_eq("cmd_valid_1cycle", int'(cmd_valid),  0);
        idle(2);

        // SPIN then LEFT, RIGHT with scaling
        send_frame("{\"T\":1,\"L\":0.02,\"R\":-0.02}", 20, -20, 1, 5'b10000);
        idle(3);
        send_frame("{\"T\":1,\"L\":-0.00,\"R\":0.050}", 0, 50, 1, 5'b01000);
        idle(3);
        send_frame("{\"T\":3,\"L\":1.5,\"R\":0.0}", 1500, 0, 3, 5'b00100);
        idle(3);

        // Fourth fraction digit is an error and must not disturb outputs
        send_str("{\"T\":1,\"L\":0.1234");
        err_exp++;
        idle(4);
        check_eq("bad_frac_err", err_seen, err_exp);
        check_held("bad_frac_hold");
        send_frame("{\"T\":2,\"L\":-1.25,\"R\":-1.25}", -1250, -1250, 2, 5'b00001);
        idle(3);

        // Resync on '{' mid-frame, then idle garbage
        err_exp++;
        send_frame("{\"T\":1,\"L{\"T\":1,\"L\":0.000,\"R\":0.000}", 0, 0, 1, 5'b00001);
        idle(3);
        check_eq("resync_err", err_seen, err_exp);
        send_str("xyz");
        send_byte(8'h0A);
        idle(4);
        check_eq("garbage_no_err", err_seen, err_exp);
        check_eq("garbage_no_cmd", cmd_seen, cmd_exp);

        // Two frames with valid held continuously across EMIT
        send_frame("{\"T\":5,\"L\":0.3,\"R\":0.7}", 300, 700, 5, 5'b01000);
        send_frame("{\"T\":6,\"L\":-0.5,\"R\":-0.9}", -500, -900, 6, 5'b00100);
        idle(4);
        check_eq("b2b_cmd_count", cmd_seen, cmd_exp);

        // Mid-frame reset returns outputs to reset values
        send_str("{\"T\":1,\"L\":0.5");
        uart_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        last_l = 0; last_r = 0; last_t = 0; last_cmd = 1;
        check_held("midrst");
        check_eq("midrst_ready", int'(uart_ready), 0);
        rst = 1'b0;
        @(negedge clk);
        send_frame("{\"T\":4,\"L\":9.999,\"R\":-9.999}", 9999, -9999, 4, 5'b10000);
        idle(4);

        check_eq("final_err_count", err_seen, err_exp);
        check_eq("final_cmd_count", cmd_seen, cmd_exp);
        check_eq("sb_drained",      sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/json_uart_parser.md
# json_uart_parser

Receive-side counterpart of the JSON motor-command sender. It consumes bytes from the UART receiver over a valid/ready byte stream and parses frames of the form {"T":d,"L":n,"R":n} terminated by LF. It converts the L/R decimal fields to signed milli-unit integers and classifies them into the one-hot motor command. Sits between `uart_rx` and the motor/command logic, so a host or loopback link can drive the same command set the sender emits.

## Interface
- `VAL_W`, default 16: width of signed speed outputs, in milli-units; must be ≥15.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `uart_data`  in  8  received byte.
- `uart_valid`  in  1  byte present on `uart_data`.
- `uart_ready`  out  1  parser accepts byte this cycle; handshake = `uart_valid && uart_ready`.
- `left_speed`  out  `VAL_W`  signed L value ×1000 from the last good frame.
- `right_speed`  out  `VAL_W`  signed R value ×1000 from the last good frame.
- `type_id`  out  4  T digit from the last good frame.
- `motor_cmd`  out  5  one-hot: STOP 00001, FORWARD 00010, RIGHT 00100, LEFT 01000, SPIN 10000.
- `cmd_valid`  out  1  one-cycle pulse when the outputs update.
- `parse_error`  out  1  one-cycle pulse on a malformed frame.

## Operation
- **Grammar**
  - Exact byte sequence: `{` `"` `T` `"` `:` D `,` `"` `L` `"` `:` NUM `,` `"` `R` `"` `:` NUM `}` LF.
  - No whitespace and no CR.
  - D is a single digit 0–9.
  - NUM is an optional `-`, exactly one integer digit, `.`, then 1–3 fraction digits.
- **NUM value** = int×1000 + f1×100 + f2×10 + f3, with missing fraction digits taken as 0, negated if `-` is present. Examples: "0.05" → 50, "1.5" → 1500, "-0.02" → -20, "-0.00" → 0.
- **State machine**
  - States: IDLE, KEY_OQ, KEY, KEY_CQ, COLON, T_DIG, SIGN_INT, DOT, FRAC, AFTER_FRAC, SEP, EOL, EMIT.
  - An expected-key register (T→L→R) selects the required key character and the required separator (`,` after T and L, `}` after R).
  - FRAC/AFTER_FRAC count fraction digits. A separator is legal only after 1–3 fraction digits.
- **IDLE**: non-`{` bytes are discarded silently, with no error.
- **Error rule**: any unexpected byte outside IDLE pulses `parse_error`, discards the partial frame, and returns to IDLE.
  - If the offending byte is `{`, it instead starts a new frame (next state KEY_OQ), and the error pulse still fires.
  - A 4th fraction digit is an error.
- **L and R staging**: values accumulate into staging registers. Outputs change only in EMIT, so partial or failed frames never alter `left_speed`, `right_speed`, `type_id` or `motor_cmd`.
- **Classification** of staged L/R, first match wins:
  1. L=0 and R=0 → STOP.
  2. L=R>0 → FORWARD.
  3. L>0, R<0, L=−R → SPIN.
  4. L>R → RIGHT.
  5. L<R → LEFT.
  6. Otherwise (L=R<0) → STOP.
- **Arithmetic**: signed, `VAL_W` bits. Magnitude ≤ 9999, so no overflow is possible.

## Timing
- **Reset values**
  - `uart_ready`=0, `left_speed`=0, `right_speed`=0, `type_id`=0, `motor_cmd`=00001, `cmd_valid`=0, `parse_error`=0.
  - State IDLE; staging registers cleared.
  - `uart_ready` rises the first cycle after `rst` deasserts.
- **Throughput**: one byte per cycle. `uart_ready` is high in every state except EMIT.
- **Frame completion**: let the LF handshake occur in cycle N.
  - Cycle N+1: state EMIT, `uart_ready`=0.
  - Cycle N+2: outputs updated, `cmd_valid`=1 for exactly one cycle, state IDLE, `uart_ready`=1.
- **Error latency**: `parse_error` is high the cycle after the offending handshake, for one cycle.
- **Simultaneous events**: `rst` overrides all; a mid-frame reset discards the frame, and the outputs return to their reset values.
- **Back-to-back frames**: a `{` arriving in cycle N+2 is accepted normally.

## Structure
- `motor_cmd_e` moves to shared package `motor_cmd_pkg`; both sender and parser import it.
- ASCII byte constants come from `ascii_inst_pkg`. Add `_MINUS`, digits 0–9, `_T`/`_L`/`_R`, `_LINE_FEED` there if absent.
- Parser state enum stays local.
- One sub-module, `json_num_accum`:
  - Purpose: decimal sign/int/fraction accumulator.
  - Inputs: clear, digit-strobe with position, sign.
  - Output: signed milli value.
  - Instantiated once and shared between L and R. Its result is latched into the L or R staging register at the separator.

## Test plan
- **FORWARD**: `{"T":1,"L":0.150,"R":0.150}`+LF, one byte/cycle → `left_speed`=150, `right_speed`=150, `type_id`=1, `motor_cmd`=00010; `cmd_valid` pulses once, 2 cycles after the LF handshake; `uart_ready` low only in cycle N+1.
- **SPIN/LEFT**: `{"T":1,"L":0.02,"R":-0.02}` → 20/−20, SPIN 10000. Then `{"T":1,"L":-0.00,"R":0.050}` → 0/50, LEFT 01000.
- **Scaling/RIGHT**: `{"T":3,"L":1.5,"R":0.0}` → 1500/0, `type_id`=3, RIGHT 00100.
- **Bad fraction**: `{"T":1,"L":0.1234,...` → `parse_error` pulses once after the `4`; outputs and `cmd_valid` unchanged. The following valid frame then decodes correctly.
- **Resync and idle garbage**: `{"T":1,"L{"T":1,"L":0.000,"R":0.000}`+LF → one `parse_error`, then STOP with `cmd_valid`. Bytes `xyz`+LF while idle → no error, no `cmd_valid`.
- **Reset and backpressure**:
  - Assert `rst` mid-frame → outputs return to reset values; the next full frame decodes.
  - Hold `uart_valid` continuously across two concatenated frames → both decoded, EMIT backpressure honored, no byte lost.
